// File: rtl/nanci_shear_pe.sv
// One processing element of the Nanci shearsort mesh: holds a single {key,data}
// record and trades it with one neighbour per cycle while the array sorts in lockstep.
module nanci_shear_pe #(
  parameter int KEY_W   = 3,
  parameter int DATA_W  = 3,
  parameter int SQRT_N  = 2,
  parameter int ROW     = 0,
  parameter int COL     = 0,
  parameter int ROUNDS  = 1,
  parameter int DESCEND = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic [KEY_W+DATA_W-1:0]   i_rec,
  input  logic                      i_start,
  input  logic [KEY_W+DATA_W-1:0]   i_PE_l,
  input  logic [KEY_W+DATA_W-1:0]   i_PE_r,
  input  logic [KEY_W+DATA_W-1:0]   i_PE_u,
  input  logic [KEY_W+DATA_W-1:0]   i_PE_d,
  output logic [KEY_W+DATA_W-1:0]   o_PE,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int W  = KEY_W + DATA_W;
  localparam int SW = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(SQRT_N - 1);
  localparam logic [RW-1:0] R_LAST = RW'((ROUNDS > 0) ? ROUNDS - 1 : 0);

  // Mesh position is fixed at elaboration, so neighbour presence and parity are constants.
  localparam logic COL_ODD = ((COL % 2) != 0);
  localparam logic ROW_ODD = ((ROW % 2) != 0);
  localparam logic HAS_L   = (COL > 0);
  localparam logic HAS_R   = (COL < SQRT_N - 1);
  localparam logic HAS_U   = (ROW > 0);
  localparam logic HAS_D   = (ROW < SQRT_N - 1);
  localparam logic DESC_B  = (DESCEND != 0);
  localparam logic ROW_ASC = (!ROW_ODD) ^ DESC_B;
  localparam logic COL_ASC = !DESC_B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROWP  = 2'd1,
    COLP  = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam state_t FIRST_PHASE = (ROUNDS > 0) ? ROWP : FINAL;

  function automatic logic [KEY_W-1:0] key_of(input logic [W-1:0] rec);
    return rec[W-1 -: KEY_W];
  endfunction

  // Equal keys hold on both sides of the pair, so a record is never duplicated or lost.
  function automatic logic [W-1:0] exchange(input logic [W-1:0] own,
                                            input logic [W-1:0] other,
                                            input logic         have,
                                            input logic         keep_min);
    logic [W-1:0] res;
    res = own;
    if (!have) begin
      res = own;
    end else if (key_of(other) == key_of(own)) begin
      res = own;
    end else if (keep_min) begin
      res = (key_of(other) < key_of(own)) ? other : own;
    end else begin
      res = (key_of(other) > key_of(own)) ? other : own;
    end
    return res;
  endfunction

  state_t          state, state_nxt;
  logic [SW-1:0]   step, step_nxt;
  logic [RW-1:0]   round, round_nxt;
  logic [W-1:0]    rec_nxt;
  logic            busy_nxt;
  logic            done_nxt;

  logic            row_face_right;
  logic            col_face_down;
  logic [W-1:0]    row_partner;
  logic [W-1:0]    col_partner;
  logic            row_have;
  logic            col_have;
  logic            row_keep_min;
  logic            col_keep_min;
  logic [W-1:0]    row_rec;
  logic [W-1:0]    col_rec;

  assign row_face_right = ~(COL_ODD ^ step[0]);
  assign col_face_down  = ~(ROW_ODD ^ step[0]);

  assign row_partner  = row_face_right ? i_PE_r : i_PE_l;
  assign row_have     = row_face_right ? HAS_R : HAS_L;
  assign row_keep_min = row_face_right ? ROW_ASC : ~ROW_ASC;
  assign row_rec      = exchange(o_PE, row_partner, row_have, row_keep_min);

  assign col_partner  = col_face_down ? i_PE_d : i_PE_u;
  assign col_have     = col_face_down ? HAS_D : HAS_U;
  assign col_keep_min = col_face_down ? COL_ASC : ~COL_ASC;
  assign col_rec      = exchange(o_PE, col_partner, col_have, col_keep_min);

  // Phase sequencing and next record/flag values.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    round_nxt = round;
    rec_nxt   = o_PE;
    busy_nxt  = o_busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_load) begin
          rec_nxt = i_rec;
        end else begin
          rec_nxt = o_PE;
        end
        if (i_start) begin
          state_nxt = FIRST_PHASE;
          busy_nxt  = 1'b1;
          step_nxt  = '0;
          round_nxt = '0;
        end else begin
          busy_nxt  = 1'b0;
        end
      end
      ROWP: begin
        rec_nxt = row_rec;
        if (step == S_LAST) begin
          step_nxt  = '0;
          state_nxt = COLP;
        end else begin
          step_nxt  = step + SW'(1);
        end
      end
      COLP: begin
        rec_nxt = col_rec;
        if (step == S_LAST) begin
          step_nxt = '0;
          if (round == R_LAST) begin
            state_nxt = FINAL;
          end else begin
            round_nxt = round + RW'(1);
            state_nxt = ROWP;
          end
        end else begin
          step_nxt = step + SW'(1);
        end
      end
      FINAL: begin
        rec_nxt = row_rec;
        if (step == S_LAST) begin
          step_nxt  = '0;
          round_nxt = '0;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          step_nxt  = step + SW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
        round_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered; reset aborts any sort in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      round  <= '0;
      o_PE   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      round  <= round_nxt;
      o_PE   <= rec_nxt;
      o_busy <= busy_nxt;
      o_done <= done_nxt;
    end
  end

endmodule
